// File: rtl/sw_bcd_counter.sv
// Stopwatch counter: NDIG mixed-radix BCD digits, run/pause FSM, tick prescaler, wrap/saturate overflow.
// Lap-freeze display register is built only when SW_LAP_EN is defined.

module sw_bcd_digit #(
   parameter bit MOD6 = 1'b0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       clr,
   input  logic       step,
   output logic [3:0] q,
   output logic [3:0] q_nxt,
   output logic       at_max
);
   localparam logic [3:0] MAXV = MOD6 ? 4'd5 : 4'd9;

   // >= so a digit can never climb past its max; it only ever rolls to 0
   assign at_max = (q >= MAXV);

   always_comb begin
      q_nxt = q;
      if (clr)       q_nxt = 4'd0;
      else if (step) q_nxt = at_max ? 4'd0 : q + 4'd1;
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) q <= 4'd0;
      else        q <= q_nxt;
endmodule

module sw_bcd_counter #(
   parameter int              NDIG       = 4,
   parameter logic [NDIG-1:0] RADIX_MASK = 4'b1010,
   parameter int              PRE_DIV    = 1,
   parameter int              WRAP       = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              TICK,
   input  logic              START_STOP,
   input  logic              CLR,
   input  logic              LAP,
   output logic [4*NDIG-1:0] VAL,
   output logic              RUN,
   output logic              OVF,
   output logic              LAP_ACT
);
   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PAUSE} state_t;

   localparam logic [7:0] PRE_LAST = 8'(PRE_DIV - 1);
   localparam bit         WRAP_EN  = (WRAP != 0);

   state_t               state, state_nxt;
   logic [7:0]           pre, pre_nxt;
   logic                 inc, all_max, ovf_evt, sat_hold;
   logic [NDIG:0]        carry;
   logic [NDIG-1:0]      at_max, step;
   logic [NDIG-1:0][3:0] live, live_nxt;
   logic [4*NDIG-1:0]    shown_nxt;

   // TICK is judged against the pre-edge state, so a starting edge ignores it
   assign inc      = (state == S_COUNT) && TICK && !CLR && (pre == PRE_LAST);
   assign all_max  = carry[NDIG];
   assign ovf_evt  = inc && all_max;
   assign sat_hold = ovf_evt && !WRAP_EN;

   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < NDIG; i++) carry[i+1] = carry[i] & at_max[i];
   end

   generate
      for (genvar g = 0; g < NDIG; g++) begin : g_dig
         assign step[g] = inc & carry[g] & ~sat_hold;
         sw_bcd_digit #(.MOD6(RADIX_MASK[g])) u_dig (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .clr    (CLR),
            .step   (step[g]),
            .q      (live[g]),
            .q_nxt  (live_nxt[g]),
            .at_max (at_max[g])
         );
      end
   endgenerate

   always_comb begin
      pre_nxt = pre;
      if (CLR)                           pre_nxt = 8'd0;
      else if (state == S_COUNT && TICK) pre_nxt = (pre == PRE_LAST) ? 8'd0 : pre + 8'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (START_STOP) state_nxt = S_COUNT;
         S_COUNT: if (START_STOP || sat_hold) state_nxt = S_PAUSE;
         // a saturated count stays parked until CLR
         S_PAUSE: if (START_STOP && !(OVF && !WRAP_EN)) state_nxt = S_COUNT;
         default: state_nxt = S_IDLE;
      endcase
      if (CLR) state_nxt = S_IDLE;
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state <= S_IDLE;
         pre   <= 8'd0;
         RUN   <= 1'b0;
         OVF   <= 1'b0;
         VAL   <= '0;
      end else begin
         state <= state_nxt;
         pre   <= pre_nxt;
         RUN   <= (state_nxt == S_COUNT);
         OVF   <= CLR ? 1'b0 : (OVF | ovf_evt);
         VAL   <= shown_nxt;
      end

`ifdef SW_LAP_EN
   logic              lap_act_nxt, lap_cap;
   logic [4*NDIG-1:0] lap_q, lap_q_nxt;

   // the lap snapshot is the count on display before the LAP edge
   assign lap_cap     = !CLR && LAP && !LAP_ACT;
   assign lap_q_nxt   = lap_cap ? live : lap_q;
   assign lap_act_nxt = CLR ? 1'b0 : (LAP ? !LAP_ACT : LAP_ACT);
   assign shown_nxt   = lap_act_nxt ? lap_q_nxt : live_nxt;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         lap_q   <= '0;
         LAP_ACT <= 1'b0;
      end else begin
         lap_q   <= lap_q_nxt;
         LAP_ACT <= lap_act_nxt;
      end
`else
   logic unused_lap;

   assign unused_lap = LAP | (|live);
   assign LAP_ACT    = 1'b0;
   assign shown_nxt  = live_nxt;
`endif
endmodule

// File: tb/tb_sw_bcd_counter.sv
// Bench for sw_bcd_counter: five parameter sets share one stimulus stream; directed table and
// sequences, then random stimulus against a count-as-integer reference model.

module tb_sw_bcd_counter;
   localparam int NI = 5;
`ifdef SW_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic CLK = 1'b0, RST_N = 1'b0, TICK = 1'b0, START_STOP = 1'b0, CLR = 1'b0, LAP = 1'b0;
   logic [15:0] val0, val1, val2;
   logic [7:0]  val3;
   logic [3:0]  val4;
   logic [NI-1:0] run, ovf, lapa;

   int c_ndig [NI] = '{4, 4, 4, 2, 1};
   int c_radix[NI] = '{10, 10, 10, 1, 0};
   int c_pre  [NI] = '{1, 1, 3, 2, 1};
   int c_wrap [NI] = '{1, 0, 1, 0, 1};

   int m_st[NI], m_n[NI], m_pre[NI], m_lapn[NI];
   bit m_ovf[NI], m_lap[NI];

   int ncmp = 0, nfail = 0;

   always #5 CLK = ~CLK;

   sw_bcd_counter u0 (.CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START_STOP(START_STOP), .CLR(CLR),
      .LAP(LAP), .VAL(val0), .RUN(run[0]), .OVF(ovf[0]), .LAP_ACT(lapa[0]));
   sw_bcd_counter #(.WRAP(0)) u1 (.CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START_STOP(START_STOP),
      .CLR(CLR), .LAP(LAP), .VAL(val1), .RUN(run[1]), .OVF(ovf[1]), .LAP_ACT(lapa[1]));
   sw_bcd_counter #(.PRE_DIV(3)) u2 (.CLK(CLK), .RST_N(RST_N), .TICK(TICK), .START_STOP(START_STOP),
      .CLR(CLR), .LAP(LAP), .VAL(val2), .RUN(run[2]), .OVF(ovf[2]), .LAP_ACT(lapa[2]));
   sw_bcd_counter #(.NDIG(2), .RADIX_MASK(2'b01), .PRE_DIV(2), .WRAP(0)) u3 (.CLK(CLK), .RST_N(RST_N),
      .TICK(TICK), .START_STOP(START_STOP), .CLR(CLR), .LAP(LAP), .VAL(val3), .RUN(run[3]),
      .OVF(ovf[3]), .LAP_ACT(lapa[3]));
   sw_bcd_counter #(.NDIG(1), .RADIX_MASK(1'b0), .PRE_DIV(1), .WRAP(1)) u4 (.CLK(CLK), .RST_N(RST_N),
      .TICK(TICK), .START_STOP(START_STOP), .CLR(CLR), .LAP(LAP), .VAL(val4), .RUN(run[4]),
      .OVF(ovf[4]), .LAP_ACT(lapa[4]));

   function automatic logic [31:0] val_of(int k);
      case (k)
         0: return {16'd0, val0};
         1: return {16'd0, val1};
         2: return {16'd0, val2};
         3: return {24'd0, val3};
         default: return {28'd0, val4};
      endcase
   endfunction

   function automatic int radix_of(int k, int i);
      return ((c_radix[k] >> i) & 1) != 0 ? 6 : 10;
   endfunction

   function automatic int total(int k);
      int t = 1;
      for (int i = 0; i < c_ndig[k]; i++) t *= radix_of(k, i);
      return t;
   endfunction

   // plain integer count rendered as mixed-radix BCD
   function automatic logic [31:0] to_bcd(int k, int n);
      logic [31:0] v = '0;
      int r = n;
      for (int i = 0; i < c_ndig[k]; i++) begin
         v[4*i +: 4] = 4'(r % radix_of(k, i));
         r = r / radix_of(k, i);
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_st[k] = 0; m_n[k] = 0; m_pre[k] = 0; m_lapn[k] = 0; m_ovf[k] = 0; m_lap[k] = 0;
      end
   endtask

   task automatic model_step(input bit ss, input bit clr, input bit tick, input bit lap);
      for (int k = 0; k < NI; k++) begin
         int ns, n0;
         bit inc;
         n0 = m_n[k];
         inc = 0;
         ns = m_st[k];
         if (clr) begin
            ns = 0; m_n[k] = 0; m_pre[k] = 0; m_ovf[k] = 0; m_lap[k] = 0;
         end else begin
            if (m_st[k] == 1 && tick) begin
               m_pre[k]++;
               if (m_pre[k] == c_pre[k]) begin m_pre[k] = 0; inc = 1; end
            end
            if (ss) begin
               if (m_st[k] == 0) ns = 1;
               else if (m_st[k] == 1) ns = 2;
               else if (!(m_ovf[k] && c_wrap[k] == 0)) ns = 1;
            end
            if (inc) begin
               if (m_n[k] == total(k) - 1) begin
                  m_ovf[k] = 1;
                  if (c_wrap[k] != 0) m_n[k] = 0;
                  else ns = 2;
               end else m_n[k]++;
            end
            if (LAP_EN && lap) begin
               if (!m_lap[k]) begin m_lap[k] = 1; m_lapn[k] = n0; end
               else m_lap[k] = 0;
            end
         end
         m_st[k] = ns;
      end
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit ss, input bit clr, input bit tick, input bit lap);
      START_STOP = ss; CLR = clr; TICK = tick; LAP = lap;
      @(posedge CLK);
      #1;
      model_step(ss, clr, tick, lap);
      START_STOP = 0; CLR = 0; TICK = 0; LAP = 0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
   endtask

   typedef struct {
      bit          ss;
      bit          clr;
      bit          tick;
      logic [15:0] val;
      bit          run;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1};

      #12 RST_N = 1'b1;
      model_reset();
      check("reset val", val_of(0), 0);
      check("reset flags", {run, ovf, lapa}, 0);

      // async reset mid-count
      cyc(1, 0, 0, 0);
      ticks(225);
      check("pre-reset val", val_of(0), 32'h0345);
      #2 RST_N = 1'b0;
      #1;
      model_reset();
      check("async reset val", val_of(0), 0);
      check("async reset run/ovf", {run[0], ovf[0]}, 0);
      #2 RST_N = 1'b1;
      ticks(3);
      check("no run after reset", {val_of(0), run[0]}, 0);

      // mixed-radix carry and both overflow policies
      cyc(1, 0, 0, 0);
      ticks(599);
      check("09:59", val_of(0), 32'h0959);
      ticks(1);
      check("10:00", val_of(0), 32'h1000);
      ticks(2999);
      check("59:59 wrap inst", val_of(0), 32'h5959);
      check("59:59 sat inst", {val_of(1), run[1], ovf[1]}, {32'h5959, 1'b1, 1'b0});
      ticks(1);
      check("wrap overflow", {val_of(0), run[0], ovf[0]}, {32'h0000, 1'b1, 1'b1});
      check("sat overflow", {val_of(1), run[1], ovf[1]}, {32'h5959, 1'b0, 1'b1});
      cyc(1, 0, 0, 0);
      check("sat start ignored", {val_of(1), run[1]}, {32'h5959, 1'b0});
      cyc(0, 1, 0, 0);
      check("sat clr", {val_of(1), ovf[1], run[1]}, 0);

      // prescaler, pause and resume
      cyc(1, 0, 0, 0);
      ticks(7);
      check("pre 7 ticks", val_of(2), 32'h0002);
      cyc(1, 0, 0, 0);
      ticks(5);
      check("pre paused", {val_of(2), run[2]}, {32'h0002, 1'b0});
      cyc(1, 0, 0, 0);
      ticks(2);
      check("pre resumed", val_of(2), 32'h0003);

      // vector table
      foreach (tbl[i]) begin
         cyc(tbl[i].ss, tbl[i].clr, tbl[i].tick, 1'b0);
         check($sformatf("tbl[%0d]", i), {val_of(0), run[0]}, {16'd0, tbl[i].val, tbl[i].run});
      end

      // lap freeze
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      ticks(12);
      check("lap pre", val_of(0), 32'h0012);
      cyc(0, 0, 0, 1);
      check("lap press", {val_of(0), lapa[0]}, {32'h0012, LAP_EN});
      ticks(5);
      check("lap frozen", {val_of(0), lapa[0]}, {(LAP_EN ? 32'h0012 : 32'h0017), LAP_EN});
      cyc(0, 0, 0, 1);
      check("lap release", {val_of(0), lapa[0]}, {32'h0017, 1'b0});

      // random stimulus against the reference model
      cyc(0, 1, 0, 0);
      for (int c = 0; c < 4000; c++) begin
         bit ss, clr, tk, lp;
         ss  = $urandom_range(0, 99) < 4;
         clr = $urandom_range(0, 199) < 2;
         tk  = $urandom_range(0, 99) < 60;
         lp  = $urandom_range(0, 99) < 3;
         cyc(ss, clr, tk, lp);
         for (int k = 0; k < NI; k++)
            check($sformatf("rand c%0d u%0d", c, k), {val_of(k), run[k], ovf[k], lapa[k]},
                  {to_bcd(k, m_lap[k] ? m_lapn[k] : m_n[k]), m_st[k] == 1, m_ovf[k], m_lap[k]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule

// File: doc/sw_bcd_counter.md
# sw_bcd_counter

Parametrised multi-digit stopwatch counter with mixed-radix BCD digits (base 10 or base 6 per digit), run/pause control, tick prescaling, overflow handling and a lap-freeze display register. It replaces the per-digit hand-wired counter chain in the stopwatch datapath. It takes a one-cycle timebase strobe and a set of debounced, single-cycle button pulses, and drives the packed BCD value to the 7-segment display mux.

## Interface
Parameters:
- NDIG, 4: number of BCD digits, 1..8.
- RADIX_MASK, 4'b1010 (width NDIG): bit i=1 makes digit i modulo 6 (max 5); bit i=0 makes it modulo 10 (max 9).
- PRE_DIV, 1: TICK pulses per count increment, 1..255.
- WRAP, 1: 1 means wrap to all-zero on overflow; 0 means saturate at all-max and stop.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- TICK  in  1  timebase strobe, one cycle wide.
- START_STOP  in  1  single-cycle pulse; toggles run/pause.
- CLR  in  1  single-cycle pulse; synchronous clear.
- LAP  in  1  single-cycle pulse; toggles lap freeze.
- VAL  out  4*NDIG  displayed BCD value; digit i at VAL[4i+3:4i], digit 0 least significant.
- RUN  out  1  high while counting.
- OVF  out  1  sticky overflow flag.
- LAP_ACT  out  1  high while the display is frozen.

## Operation
- FSM with three states:
  - IDLE: count is zero, RUN=0.
  - COUNT: RUN=1.
  - PAUSE: count is held, RUN=0.
- FSM transitions:
  - IDLE to COUNT on START_STOP.
  - COUNT to PAUSE on START_STOP.
  - PAUSE to COUNT on START_STOP.
  - Any state to IDLE on CLR.
- Prescaler:
  - 8-bit counter advances on each TICK while in COUNT; frozen in PAUSE.
  - On TICK with prescaler == PRE_DIV-1 it resets to 0 and an increment event (INC) fires.
- Digit carry:
  - Digit i increments on INC when every digit j<i is at its max.
  - A digit at its max rolls to 0 instead of incrementing.
  - All digits update in the same edge; the carry chain is combinational.
- Overflow, when all digits are at max and INC fires:
  - WRAP=1: all digits go to 0, OVF is set, and the FSM stays in COUNT.
  - WRAP=0: digits hold at max, OVF is set, and the FSM goes to PAUSE.
  - In PAUSE with OVF=1 and WRAP=0, START_STOP is ignored.
- CLR:
  - Clears digits, prescaler, OVF and the lap state; FSM goes to IDLE.
  - Has priority over START_STOP, LAP and TICK in the same cycle.
- Same-cycle START_STOP and TICK: the TICK is evaluated against the state before the edge. A TICK in the cycle that starts the count is ignored; a TICK in the cycle that stops it is counted.
- Digit values never leave 0..max, for every parameter combination.

## Timing
- Reset (RST_N low): VAL=0, RUN=0, OVF=0, LAP_ACT=0, prescaler=0, FSM=IDLE. Reset takes effect immediately, including mid-count or mid-lap.
- All outputs are registered.
- Latency from an input to its effect is one clock:
  - A qualifying TICK at edge k changes VAL, unless frozen, after edge k.
  - START_STOP at edge k changes RUN after edge k.
- Input pulses are edge-sampled only. A level held across N cycles acts as N pulses; callers must supply single-cycle pulses.

## Configuration
- Macro: `SW_LAP_EN`.
- Defined:
  - LAP pressed while LAP_ACT=0 copies the live count into the lap register and sets LAP_ACT.
  - VAL then shows the lap register while counting continues underneath.
  - LAP pressed while LAP_ACT=1 clears LAP_ACT, so VAL shows the live count again.
  - LAP is accepted in any state; CLR clears LAP_ACT.
- Undefined: the lap register is not built, LAP is ignored, LAP_ACT is tied to 0, and VAL always shows the live count.

## Test plan
- Reset: RST_N=0 while counting 0x0345. VAL=0, RUN=0 and OVF=0 immediately; after release, the count does not advance without a START_STOP.
- Mixed-radix carry (defaults): preload to 0x0959 (09:59), then 1 TICK gives VAL=0x1000; after 0x5959, 1 TICK gives VAL=0x0000, OVF=1, RUN=1.
- Saturating overflow: WRAP=0 at 0x5959, TICK gives VAL=0x5959, OVF=1, RUN=0; a following START_STOP leaves RUN=0; CLR gives VAL=0, OVF=0.
- Prescaler: PRE_DIV=3, 7 TICKs while counting give VAL=0x0002; pause after the 7th, 5 TICKs leave VAL unchanged; resume, 2 TICKs give VAL=0x0003.
- Simultaneous events: START_STOP with TICK from IDLE gives VAL=0; CLR with START_STOP and TICK gives IDLE and VAL=0.
- Lap (`SW_LAP_EN` defined): LAP at 0x0012, then 5 TICKs give VAL=0x0012 with LAP_ACT=1; a second LAP gives VAL=0x0017. With the macro undefined, the same sequence keeps LAP_ACT=0 and VAL live.
